// File: rtl/vc_pop_arbiter_if.sv
// VC-drain arbiter bus: VC FIFO read side, destination FIFO write side, status.
// Purely a signal bundle with no latency of its own.
// Backpressure arrives on D0/D1_almost_full; VCx_rd is the pop strobe.
interface vc_pop_arbiter_if #(
  parameter int DATA_WIDTH = 6,
  parameter int CNT_WIDTH  = 8
);
  // VC FIFO read side (first-word-fall-through heads)
  logic                  VC0_empty;
  logic [DATA_WIDTH-1:0] VC0_data_out;
  logic                  VC1_empty;
  logic [DATA_WIDTH-1:0] VC1_data_out;
  logic                  VC0_rd;
  logic                  VC1_rd;

  // Destination FIFO write side
  logic                  D0_almost_full;
  logic                  D1_almost_full;
  logic                  D0_push;
  logic                  D1_push;
  logic [DATA_WIDTH-1:0] D_data_in;

  // Status
  logic [CNT_WIDTH-1:0]  D0_count;
  logic [CNT_WIDTH-1:0]  D1_count;
  logic                  idle;

  // Arbiter side
  modport slave (
    input  VC0_empty, VC0_data_out, VC1_empty, VC1_data_out,
    input  D0_almost_full, D1_almost_full,
    output VC0_rd, VC1_rd, D0_push, D1_push, D_data_in,
    output D0_count, D1_count, idle
  );

  // Environment side (FIFOs / bench)
  modport master (
    output VC0_empty, VC0_data_out, VC1_empty, VC1_data_out,
    output D0_almost_full, D1_almost_full,
    input  VC0_rd, VC1_rd, D0_push, D1_push, D_data_in,
    input  D0_count, D1_count, idle
  );
endinterface

// File: rtl/vc_pop_arbiter.sv
// Drains VC0/VC1 into D0/D1, routing on the word's destination bit; VC0 has
// strict priority with a burst limit that forces a VC1 grant.
// Latency: 1 cycle from VCx_rd to Dy_push. Backpressure: a VC whose head targets an almost-full D is skipped.
module vc_pop_arbiter #(
  parameter int DATA_WIDTH = 6,
  parameter int BURST_MAX  = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  vc_pop_arbiter_if.slave   bus
);

  localparam int             BW   = $clog2(BURST_MAX + 1);
  localparam int             DSEL = DATA_WIDTH - 2;
  localparam logic [BW-1:0]  BMAX = BW'(BURST_MAX);

  typedef enum logic {
    PRIO_VC0  = 1'b0,
    FORCE_VC1 = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic                  gnt0, gnt1, gnt_any;
  logic                  vc0_elig, vc1_elig;
  logic [DATA_WIDTH-1:0] word_sel;
  logic                  dest_sel;

  logic                  d0_push_q, d1_push_q;
  logic [DATA_WIDTH-1:0] d_data_q;
  logic [CNT_WIDTH-1:0]  d0_cnt_q, d1_cnt_q;
  logic                  idle_q;

  // A head word is eligible only if its own destination has room; the two
  // VCs are judged independently so one blocked head never stalls the other.
  assign vc0_elig = !bus.VC0_empty &&
                    !(bus.VC0_data_out[DSEL] ? bus.D1_almost_full : bus.D0_almost_full);
  assign vc1_elig = !bus.VC1_empty &&
                    !(bus.VC1_data_out[DSEL] ? bus.D1_almost_full : bus.D0_almost_full);

  // Grant selection, burst counting and priority-state next-state logic.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    if (!reset) begin
      case (state_q)
        PRIO_VC0: begin
          if (vc0_elig)      gnt0 = 1'b1;
          else if (vc1_elig) gnt1 = 1'b1;
        end
        FORCE_VC1: begin
          if (vc1_elig)      gnt1 = 1'b1;
          else if (vc0_elig) gnt0 = 1'b1;
        end
        default: ;
      endcase

      // The burst only counts while VC1 actually has something waiting;
      // saturate so a blocked VC1 in FORCE_VC1 cannot wrap the counter.
      if (bus.VC1_empty || gnt1) begin
        bcnt_d = '0;
      end else if (gnt0 && (bcnt_q != BMAX)) begin
        bcnt_d = bcnt_q + BW'(1);
      end

      case (state_q)
        PRIO_VC0:  if (bcnt_d == BMAX) state_d = FORCE_VC1;
        FORCE_VC1: if (gnt1 || bus.VC1_empty) state_d = PRIO_VC0;
        default:   state_d = PRIO_VC0;
      endcase
    end
  end

  assign gnt_any  = gnt0 | gnt1;
  assign word_sel = gnt0 ? bus.VC0_data_out : bus.VC1_data_out;
  assign dest_sel = word_sel[DSEL];

  // Arbiter state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PRIO_VC0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Push stage: register the granted word and steer it to D0 or D1; reset
  // drops any word still sitting here.
  always_ff @(posedge clk) begin
    if (reset) begin
      d0_push_q <= 1'b0;
      d1_push_q <= 1'b0;
      d_data_q  <= '0;
      idle_q    <= 1'b1;
    end else begin
      d0_push_q <= gnt_any & ~dest_sel;
      d1_push_q <= gnt_any &  dest_sel;
      d_data_q  <= gnt_any ? word_sel : '0;
      idle_q    <= bus.VC0_empty & bus.VC1_empty & ~gnt0 & ~gnt1;
    end
  end

  // Per-destination word counters, advanced by each completed push, wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      d0_cnt_q <= '0;
      d1_cnt_q <= '0;
    end else begin
      if (d0_push_q) d0_cnt_q <= d0_cnt_q + CNT_WIDTH'(1);
      if (d1_push_q) d1_cnt_q <= d1_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign bus.VC0_rd    = gnt0;
  assign bus.VC1_rd    = gnt1;
  assign bus.D0_push   = d0_push_q;
  assign bus.D1_push   = d1_push_q;
  assign bus.D_data_in = d_data_q;
  assign bus.D0_count  = d0_cnt_q;
  assign bus.D1_count  = d1_cnt_q;
  assign bus.idle      = idle_q;

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Bench for vc_pop_arbiter: grant-decision vectors plus multi-cycle sequences,
// with a queue scoreboard matching each VC pop to the D push one cycle later.
// VC FIFOs are modelled as queues feeding first-word-fall-through heads.
module tb_vc_pop_arbiter;

  localparam int DW = 6;
  localparam int CW = 8;
  localparam int BM = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vc_pop_arbiter_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  vc_pop_arbiter #(.DATA_WIDTH(DW), .BURST_MAX(BM), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [DW-1:0] vc0_q[$];
  logic [DW-1:0] vc1_q[$];
  logic [DW-1:0] sb_q[$];
  int            gnt_log[$];
  bit            model_on = 1'b0;

  typedef struct {
    logic          e0;
    logic [DW-1:0] d0;
    logic          e1;
    logic [DW-1:0] d1;
    logic          af0;
    logic          af1;
    logic          rd0;
    logic          rd1;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic update_vc();
    bus.VC0_empty = (vc0_q.size() == 0);
    bus.VC1_empty = (vc1_q.size() == 0);
    if (vc0_q.size() != 0) bus.VC0_data_out = vc0_q[0]; else bus.VC0_data_out = '0;
    if (vc1_q.size() != 0) bus.VC1_data_out = vc1_q[0]; else bus.VC1_data_out = '0;
  endtask

  task automatic load(input int vc, input logic [DW-1:0] w);
    if (vc == 0) vc0_q.push_back(w); else vc1_q.push_back(w);
    update_vc();
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic drain(input int budget, input string name);
    int c;
    c = 0;
    while (((vc0_q.size() + vc1_q.size()) != 0) && (c < budget)) begin
      tick();
      c++;
    end
    chk(name, vc0_q.size() + vc1_q.size(), 0);
    tick();
    tick();
  endtask

  // Monitor: at each edge record the grant, pop the VC model, enqueue the
  // expected word; just after the edge check the registered push against it.
  always @(posedge clk) begin : mon
    logic          g0, g1, rst_s, e_s, af_s;
    logic [DW-1:0] w, expw;
    g0    = bus.VC0_rd;
    g1    = bus.VC1_rd;
    rst_s = reset;
    w     = g0 ? bus.VC0_data_out : bus.VC1_data_out;
    e_s   = g0 ? bus.VC0_empty : bus.VC1_empty;
    af_s  = w[DW-2] ? bus.D1_almost_full : bus.D0_almost_full;
    #1;
    if (rst_s) begin
      sb_q.delete();
    end else begin
      if (g0 | g1) begin
        chk("rd_onehot", g0 & g1, 0);
        chk("pop_nonempty", e_s, 0);
        chk("dest_not_af", af_s, 0);
        sb_q.push_back(w);
        gnt_log.push_back(g1 ? 1 : 0);
        if (model_on) begin
          if (g0 && vc0_q.size() != 0) void'(vc0_q.pop_front());
          if (g1 && vc1_q.size() != 0) void'(vc1_q.pop_front());
          update_vc();
        end
      end
      chk("push_strobe", bus.D0_push | bus.D1_push, sb_q.size() != 0);
      if (sb_q.size() != 0) begin
        expw = sb_q.pop_front();
        chk("push_data", bus.D_data_in, expw);
        chk("push_dest", {bus.D1_push, bus.D0_push}, expw[DW-2] ? 2'b10 : 2'b01);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    int   exp_ord[20];

    vecs[0] = '{1'b1, 6'h00, 1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 6'h05, 1'b1, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 6'h05, 1'b0, 6'h15, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 6'h05, 1'b0, 6'h15, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 6'h15, 1'b0, 6'h15, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 6'h05, 1'b0, 6'h15, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 6'h00, 1'b0, 6'h05, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 6'h15, 1'b0, 6'h05, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 6'h00, 1'b0, 6'h05, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 6'h15, 1'b0, 6'h25, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_ord = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};

    bus.D0_almost_full = 1'b0;
    bus.D1_almost_full = 1'b0;
    update_vc();

    // Reset held two cycles with both VCs holding words.
    model_on = 1'b1;
    load(0, 6'h05);
    load(1, 6'h15);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_rd", {bus.VC1_rd, bus.VC0_rd}, 2'b00);
      tick();
    end
    reset = 1'b0;
    @(negedge clk);
    chk("rst_d0_push", bus.D0_push, 0);
    chk("rst_d1_push", bus.D1_push, 0);
    chk("rst_data", bus.D_data_in, 0);
    chk("rst_d0_count", bus.D0_count, 0);
    chk("rst_d1_count", bus.D1_count, 0);
    chk("rst_idle", bus.idle, 1);
    drain(20, "a_drain");

    // Single-cycle grant decisions from a fresh PRIO_VC0 state.
    model_on = 1'b0;
    foreach (vecs[i]) begin
      do_reset(1);
      bus.VC0_empty      = vecs[i].e0;
      bus.VC0_data_out   = vecs[i].d0;
      bus.VC1_empty      = vecs[i].e1;
      bus.VC1_data_out   = vecs[i].d1;
      bus.D0_almost_full = vecs[i].af0;
      bus.D1_almost_full = vecs[i].af1;
      @(negedge clk);
      chk($sformatf("vec%0d_rd", i), {bus.VC1_rd, bus.VC0_rd}, {vecs[i].rd1, vecs[i].rd0});
      tick();
      bus.D0_almost_full = 1'b0;
      bus.D1_almost_full = 1'b0;
      update_vc();
      tick();
    end
    model_on = 1'b1;
    update_vc();

    // Two words from VC0 to D0 then D1, VC1 empty.
    do_reset(1);
    load(0, 6'h05);
    load(0, 6'h15);
    @(negedge clk);
    chk("b_rd0_c1", {bus.VC1_rd, bus.VC0_rd}, 2'b01);
    tick();
    @(negedge clk);
    chk("b_rd0_c2", {bus.VC1_rd, bus.VC0_rd}, 2'b01);
    chk("b_busy_idle", bus.idle, 0);
    tick();
    @(negedge clk);
    chk("b_rd_done", {bus.VC1_rd, bus.VC0_rd}, 2'b00);
    tick();
    tick();
    chk("b_d0_count", bus.D0_count, 1);
    chk("b_d1_count", bus.D1_count, 1);
    chk("b_idle", bus.idle, 1);

    // Burst limit: ten D0 words in each VC.
    do_reset(1);
    gnt_log.delete();
    for (int i = 0; i < 10; i++) begin
      load(0, DW'(i));
      load(1, DW'(32 + i));
    end
    drain(100, "c_drain");
    chk("c_log_len", gnt_log.size(), 20);
    for (int i = 0; i < 20; i++)
      chk($sformatf("c_order%0d", i), (i < gnt_log.size()) ? gnt_log[i] : 99, exp_ord[i]);
    chk("c_d0_count", bus.D0_count, 20);

    // VC0 head blocked by D0 almost_full, VC1 heads to free D1.
    do_reset(1);
    bus.D0_almost_full = 1'b1;
    load(0, 6'h05);
    load(1, 6'h15);
    @(negedge clk);
    chk("d_rd_bypass", {bus.VC1_rd, bus.VC0_rd}, 2'b10);
    tick();
    @(negedge clk);
    chk("d_d1_push", bus.D1_push, 1);
    chk("d_rd_blocked", {bus.VC1_rd, bus.VC0_rd}, 2'b00);
    tick();
    bus.D0_almost_full = 1'b0;
    @(negedge clk);
    chk("d_rd_release", {bus.VC1_rd, bus.VC0_rd}, 2'b01);
    drain(10, "d_drain");

    // D1 counter wrap: 255 words, then one more.
    do_reset(1);
    for (int i = 0; i < 255; i++) load(1, 6'h15);
    drain(400, "e_drain1");
    chk("e_d1_255", bus.D1_count, 255);
    chk("e_d0_zero", bus.D0_count, 0);
    load(1, 6'h15);
    drain(10, "e_drain2");
    chk("e_d1_wrap", bus.D1_count, 0);

    // Reset right after the fourth VC0 grant, while FORCE_VC1 is pending.
    do_reset(1);
    for (int i = 0; i < 8; i++) load(0, 6'h05);
    for (int i = 0; i < 4; i++) load(1, 6'h25);
    repeat (4) tick();
    chk("f_push_inflight", bus.D0_push, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("f_rst_rd", {bus.VC1_rd, bus.VC0_rd}, 2'b00);
    tick();
    chk("f_no_push", bus.D0_push, 0);
    chk("f_data", bus.D_data_in, 0);
    chk("f_d0_count", bus.D0_count, 0);
    chk("f_idle", bus.idle, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("f_prio_restored", {bus.VC1_rd, bus.VC0_rd}, 2'b01);
    drain(40, "f_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
